// File: rtl/nibble_alu_pkg.sv
// Shared types and helpers for the nibble-serial add/subtract controller.
package nibble_alu_pkg;

    localparam int unsigned NIBBLE_W = 4;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    typedef struct packed {
        logic c;
        logic v;
        logic n;
        logic z;
    } alu_flags_t;

    // Most-positive (neg=0) or most-negative (neg=1) two's-complement value of a given width.
    function automatic logic [63:0] sat_limit(input int unsigned width, input logic neg);
        logic [63:0] msb;
        msb = 64'd1 << (width - 1);
        sat_limit = neg ? msb : (msb - 64'd1);
    endfunction

endpackage

// File: rtl/nibble_addsub_slice.sv
// Combinational 4-bit ripple full-adder slice; exposes the carry into bit 3 for overflow detection.
module nibble_addsub_slice
    import nibble_alu_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);

    logic [NIBBLE_W:0] c;

    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = cin;
        for (int i = 0; i < NIBBLE_W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
    end

    assign cout = c[NIBBLE_W];
    assign c3   = c[NIBBLE_W-1];

endmodule

// File: rtl/nibble_serial_alu_ctrl.sv
// WIDTH-bit add/subtract computed one nibble per cycle through a single shared slice.
// Define NIBBLE_ALU_SAT_EN to saturate the result on signed overflow.
module nibble_serial_alu_ctrl
    import nibble_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_s,
    output logic             out_c,
    output logic             out_v,
    output logic             out_n,
    output logic             out_z
);

    localparam int unsigned NIB   = WIDTH / NIBBLE_W;
    localparam int unsigned CNT_W = $clog2(NIB);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    alu_flags_t       flags_q, flags_d;
    logic             out_valid_q, out_valid_d;

    logic [NIBBLE_W-1:0] slice_b;
    logic [NIBBLE_W-1:0] slice_s;
    logic                slice_cout;
    logic                slice_c3;
    logic [WIDTH-1:0]    final_s;
    logic [WIDTH-1:0]    final_out;
    logic                v_ovf;
    logic                last_nib;

    // Subtraction is A + ~B + 1; the +1 comes from the carry register preset at accept.
    assign slice_b = sub_q ? ~b_q[NIBBLE_W-1:0] : b_q[NIBBLE_W-1:0];

    nibble_addsub_slice u_slice (
        .a    (a_q[NIBBLE_W-1:0]),
        .b    (slice_b),
        .cin  (carry_q),
        .s    (slice_s),
        .cout (slice_cout),
        .c3   (slice_c3)
    );

    assign final_s  = {slice_s, res_q[WIDTH-1:NIBBLE_W]};
    assign v_ovf    = slice_c3 ^ slice_cout;
    assign last_nib = (cnt_q == CNT_W'(NIB - 1));

`ifdef NIBBLE_ALU_SAT_EN
    logic [WIDTH-1:0] sat_val;

    // On the last nibble a_q[3] is the original sign bit of A.
    assign sat_val   = WIDTH'(sat_limit(WIDTH, a_q[NIBBLE_W-1]));
    assign final_out = v_ovf ? sat_val : final_s;
`else
    assign final_out = final_s;
`endif

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        res_d       = res_q;
        s_d         = s_q;
        sub_d       = sub_q;
        carry_d     = carry_q;
        cnt_d       = cnt_q;
        flags_d     = flags_q;
        out_valid_d = out_valid_q;
        in_ready    = 1'b0;

        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = in_a;
                    b_d     = in_b;
                    sub_d   = in_sub;
                    carry_d = in_sub;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                carry_d = slice_cout;
                a_d     = a_q >> NIBBLE_W;
                b_d     = b_q >> NIBBLE_W;
                res_d   = final_s;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_nib) begin
                    s_d         = final_out;
                    flags_d.c   = slice_cout;
                    flags_d.v   = v_ovf;
                    flags_d.n   = final_out[WIDTH-1];
                    flags_d.z   = (final_out == '0);
                    out_valid_d = 1'b1;
                    state_d     = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            s_q         <= '0;
            sub_q       <= 1'b0;
            carry_q     <= 1'b0;
            cnt_q       <= '0;
            flags_q     <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            s_q         <= s_d;
            sub_q       <= sub_d;
            carry_q     <= carry_d;
            cnt_q       <= cnt_d;
            flags_q     <= flags_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_s     = s_q;
    assign out_c     = flags_q.c;
    assign out_v     = flags_q.v;
    assign out_n     = flags_q.n;
    assign out_z     = flags_q.z;

endmodule
